// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arithmetic core: op codes, FSM states
// and the decimal scale helper.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_MUL  = 3'd2;
    localparam state_t ST_DIV  = 3'd3;
    localparam state_t ST_FIX  = 3'd4;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/seq_udiv.sv
// Fixed-latency unsigned restoring divider: the first step runs on the load
// edge, so the quotient is ready N edges after load.
module seq_udiv #(
    parameter int unsigned N = 64,
    parameter int unsigned D = 33
) (
    input  logic         clk_db,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] dividend,
    input  logic [D-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic         valid
);
    localparam int unsigned CW = $clog2(N);

    logic [N-1:0]  quo_q, quo_d, quo_in, quo_st;
    logic [D-1:0]  rem_q, rem_d, rem_in, rem_st;
    logic [D-1:0]  dsr_q, dsr_d, dsr_in;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [D:0]    rem_sh;
    logic          ge;

    always_comb begin
        rem_in  = rem_q;
        quo_in  = quo_q;
        dsr_in  = dsr_q;
        if (load) begin
            rem_in = '0;
            quo_in = dividend;
            dsr_in = divisor;
        end
        rem_sh = {rem_in, quo_in[N-1]};
        ge     = rem_sh >= {1'b0, dsr_in};
        // remainder stays below the divisor, so the low D bits are exact
        rem_st = ge ? rem_sh[D-1:0] - dsr_in : rem_sh[D-1:0];
        quo_st = {quo_in[N-2:0], ge};

        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (clear) begin
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (load) begin
            rem_d   = rem_st;
            quo_d   = quo_st;
            dsr_d   = divisor;
            cnt_d   = CW'(N - 1);
            valid_d = 1'b0;
        end else if (cnt_q != '0) begin
            rem_d   = rem_st;
            quo_d   = quo_st;
            cnt_d   = cnt_q - CW'(1);
            valid_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk_db or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign quotient = quo_q;
    assign valid    = valid_q;

endmodule

// File: rtl/calc_alu_seq.sv
// Sequential signed fixed-point add/sub/mul/div core with saturation,
// divide-by-zero reporting and result chaining.
module calc_alu_seq
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned FRAC_DIGITS = 4
) (
    input  logic             clk_db,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             use_prev,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err_div0,
    output logic             err_ovf
);
    localparam int unsigned     W2    = 2 * WIDTH;
    localparam int unsigned     WA    = WIDTH + 1;
    localparam int unsigned     MCW   = $clog2(WIDTH);
    localparam longint unsigned SCALE = pow10(FRAC_DIGITS);

    localparam logic [W2-1:0]    MAG_NEG = W2'(1) << (WIDTH - 1);
    localparam logic [W2-1:0]    MAG_POS = MAG_NEG - W2'(1);
    localparam logic [WIDTH-1:0] RES_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] RES_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WA-1:0]    sum_q, sum_d;
    logic [W2-1:0]    prod_q, prod_d, mcand_q, mcand_d;
    logic [WA-1:0]    mplier_q, mplier_d;
    logic [MCW-1:0]   mcnt_q, mcnt_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             err_div0_q, err_div0_d, err_ovf_q, err_ovf_d;

    logic [WA-1:0]    a_ext, b_ext, a_abs, b_abs;
    logic             neg_c;
    logic             div_load_c;
    logic [W2-1:0]    div_dvd_c, div_quo;
    logic [WA-1:0]    div_dsr_c;
    logic             div_valid;

    // Magnitudes in WIDTH+1 bits so the most-negative operand is representable
    assign a_ext = {a_q[WIDTH-1], a_q};
    assign b_ext = {b_q[WIDTH-1], b_q};
    assign a_abs = a_ext[WA-1] ? -a_ext : a_ext;
    assign b_abs = b_ext[WA-1] ? -b_ext : b_ext;
    assign neg_c = a_q[WIDTH-1] ^ b_q[WIDTH-1];

    seq_udiv #(
        .N(W2),
        .D(WA)
    ) u_div (
        .clk_db   (clk_db),
        .rst_n    (rst_n),
        .clear    (clear),
        .load     (div_load_c),
        .dividend (div_dvd_c),
        .divisor  (div_dsr_c),
        .quotient (div_quo),
        .valid    (div_valid)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        prod_d     = prod_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        mcnt_d     = mcnt_q;
        div0_d     = div0_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_div0_d = err_div0_q;
        err_ovf_d  = err_ovf_q;
        div_load_c = 1'b0;
        div_dvd_c  = '0;
        div_dsr_c  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    op_d       = op;
                    a_d        = use_prev ? result_q : a;
                    b_d        = b;
                    busy_d     = 1'b1;
                    err_div0_d = 1'b0;
                    err_ovf_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                div0_d = 1'b0;
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        sum_d   = (op_q == OP_SUB) ? a_ext - b_ext : a_ext + b_ext;
                        state_d = ST_FIX;
                    end
                    OP_MUL: begin
                        // first shift-add step folded into this edge
                        prod_d   = b_abs[0] ? W2'(a_abs) : '0;
                        mcand_d  = W2'(a_abs) << 1;
                        mplier_d = b_abs >> 1;
                        mcnt_d   = MCW'(WIDTH - 1);
                        state_d  = ST_MUL;
                    end
                    default: begin
                        if (b_abs == '0) begin
                            div0_d  = 1'b1;
                            state_d = ST_FIX;
                        end else begin
                            div_load_c = 1'b1;
                            div_dvd_c  = W2'(a_abs) * W2'(SCALE);
                            div_dsr_c  = b_abs;
                            state_d    = ST_DIV;
                        end
                    end
                endcase
            end
            ST_MUL: begin
                if (mcnt_q != '0) begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    mcnt_d   = mcnt_q - MCW'(1);
                end else begin
                    div_load_c = 1'b1;
                    div_dvd_c  = prod_q;
                    div_dsr_c  = WA'(SCALE);
                    state_d    = ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_valid) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (op_q == OP_ADD || op_q == OP_SUB) begin
                    if (sum_q[WA-1] != sum_q[WA-2]) begin
                        result_d  = sum_q[WA-1] ? RES_MIN : RES_MAX;
                        err_ovf_d = 1'b1;
                    end else begin
                        result_d = sum_q[WIDTH-1:0];
                    end
                end else if (div0_q) begin
                    result_d   = '0;
                    err_div0_d = 1'b1;
                end else if (neg_c) begin
                    if (div_quo > MAG_NEG) begin
                        result_d  = RES_MIN;
                        err_ovf_d = 1'b1;
                    end else begin
                        result_d = -div_quo[WIDTH-1:0];
                    end
                end else begin
                    if (div_quo > MAG_POS) begin
                        result_d  = RES_MAX;
                        err_ovf_d = 1'b1;
                    end else begin
                        result_d = div_quo[WIDTH-1:0];
                    end
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // clear wins over start and over every state
        if (clear) begin
            state_d    = ST_IDLE;
            result_d   = '0;
            err_div0_d = 1'b0;
            err_ovf_d  = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            div_load_c = 1'b0;
        end
    end

    always_ff @(posedge clk_db or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            prod_q     <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            mcnt_q     <= '0;
            div0_q     <= 1'b0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_div0_q <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            prod_q     <= prod_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            mcnt_q     <= mcnt_d;
            div0_q     <= div0_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_div0_q <= err_div0_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign err_div0 = err_div0_q;
    assign err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_calc_alu_seq.sv
// Scoreboard bench for calc_alu_seq: directed and random operations checked
// against a plain-arithmetic reference model.
module tb_calc_alu_seq;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned FRAC    = 4;
    localparam longint      SCALE   = 10000;
    localparam longint      MAXV    = 64'sd2147483647;
    localparam longint      MINV    = -64'sd2147483648;
    localparam int          LAT_ADD = 2;
    localparam int          LAT_DIV = 2 * WIDTH + 2;
    localparam int          LAT_MUL = 3 * WIDTH + 2;

    logic             clk_db, rst_n, clear, start, use_prev;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, err_div0, err_ovf;
    logic [WIDTH-1:0] result;

    typedef struct {
        longint res;
        bit     d0;
        bit     ov;
        int     due;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   mon_e;
    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;
    int     done_cnt = 0;
    longint model_res = 0;

    calc_alu_seq #(
        .WIDTH       (WIDTH),
        .FRAC_DIGITS (FRAC)
    ) dut (
        .clk_db   (clk_db),
        .rst_n    (rst_n),
        .clear    (clear),
        .start    (start),
        .op       (op),
        .use_prev (use_prev),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .err_div0 (err_div0),
        .err_ovf  (err_ovf)
    );

    initial clk_db = 1'b0;
    always #5 clk_db = ~clk_db;
    always @(posedge clk_db) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference: real-valued fixed-point arithmetic, truncating toward zero
    function automatic void ref_op(input logic [1:0] o, input longint x, input longint y,
                                   output longint r, output bit d0, output bit ov);
        longint v;
        v  = 0;
        d0 = 1'b0;
        case (o)
            2'd0:    v = x + y;
            2'd1:    v = x - y;
            2'd2:    v = (x * y) / SCALE;
            default: if (y == 0) d0 = 1'b1; else v = (x * SCALE) / y;
        endcase
        ov = (v > MAXV) || (v < MINV);
        r  = (v > MAXV) ? MAXV : ((v < MINV) ? MINV : v);
    endfunction

    function automatic int rand_operand();
        case ($urandom_range(0, 4))
            0:       return int'($urandom_range(0, 400000)) - 200000;
            1:       return int'($urandom);
            2:       return ($urandom_range(0, 1) == 1) ? int'(32'h7fffffff) : int'(32'h80000000);
            3:       return 0;
            default: return int'($urandom_range(0, 20000000)) - 10000000;
        endcase
    endfunction

    task automatic issue(input logic [1:0] o, input int x, input int y, input bit up);
        exp_t   e;
        longint av, r;
        bit     d0, ov;
        int     lat;
        @(negedge clk_db);
        av = up ? model_res : longint'(x);
        ref_op(o, av, longint'(y), r, d0, ov);
        lat   = (o == 2'd2) ? LAT_MUL : ((o == 2'd3 && y != 0) ? LAT_DIV : LAT_ADD);
        e.res = r;
        e.d0  = d0;
        e.ov  = ov;
        e.due = cyc + 1 + lat;
        sb_q.push_back(e);
        model_res = r;
        op       = o;
        a        = x;
        b        = y;
        use_prev = up;
        start    = 1'b1;
        @(negedge clk_db);
        start    = 1'b0;
        use_prev = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n0;
        int t;
        n0 = done_cnt;
        t  = 0;
        while (done_cnt == n0 && t < 400) begin
            @(negedge clk_db);
            t++;
        end
        chk({name, "_done_seen"}, longint'(done_cnt - n0), 1);
    endtask

    task automatic run(input string name, input logic [1:0] o, input int x, input int y, input bit up);
        issue(o, x, y, up);
        wait_done(name);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk_db) begin
        if (rst_n && done) begin
            done_cnt++;
            chk("scoreboard_nonempty_at_done", longint'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("result",   longint'($signed(result)), mon_e.res);
                chk("err_div0", longint'(err_div0), longint'(mon_e.d0));
                chk("err_ovf",  longint'(err_ovf),  longint'(mon_e.ov));
                chk("latency",  longint'(cyc),      longint'(mon_e.due));
            end
        end
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        clear    = 1'b0;
        start    = 1'b0;
        op       = 2'd0;
        use_prev = 1'b0;
        a        = '0;
        b        = '0;
        #1;
        chk("reset_busy",     longint'(busy), 0);
        chk("reset_done",     longint'(done), 0);
        chk("reset_result",   longint'(result), 0);
        chk("reset_err_div0", longint'(err_div0), 0);
        chk("reset_err_ovf",  longint'(err_ovf), 0);
        repeat (3) @(negedge clk_db);
        rst_n = 1'b1;

        run("add", 2'd0, 15000, 22500, 1'b0);

        // mul with a second start issued mid-operation
        issue(2'd2, 15000, -20000, 1'b0);
        repeat (10) @(negedge clk_db);
        chk("busy_mid_mul", longint'(busy), 1);
        start = 1'b1;
        op    = 2'd0;
        a     = 32'd1;
        b     = 32'd1;
        @(negedge clk_db);
        start = 1'b0;
        chk("busy_after_ignored_start", longint'(busy), 1);
        wait_done("mul");
        n = done_cnt;
        repeat (6) @(negedge clk_db);
        chk("no_done_from_ignored_start", longint'(done_cnt - n), 0);
        chk("scoreboard_drained", longint'(sb_q.size()), 0);

        run("div",        2'd3, 10000, 30000, 1'b0);
        run("chain_mul",  2'd2, 0, 30000, 1'b1);
        run("div_zero",   2'd3, 12345, 0, 1'b0);
        run("add_after0", 2'd0, 10000, 10000, 1'b0);
        run("add_ovf",    2'd0, int'(32'h7fffffff), 1, 1'b0);
        run("sub_ovf",    2'd1, int'(32'h80000000), 1, 1'b0);
        run("mul_ovf",    2'd2, 2000000000, 2000000000, 1'b0);
        run("mul_min",    2'd2, int'(32'h80000000), -10000, 1'b0);
        run("div_min",    2'd3, int'(32'h80000000), 10000, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [1:0] ro;
            int         rx, ry;
            bit         ru;
            ro = 2'($urandom_range(0, 3));
            rx = rand_operand();
            ry = rand_operand();
            ru = ($urandom_range(0, 3) == 0);
            run("random", ro, rx, ry, ru);
        end

        // clear 10 cycles into a multiply
        run("pre_clear_add", 2'd0, 10000, 5000, 1'b0);
        issue(2'd2, 15000, 20000, 1'b0);
        repeat (9) @(negedge clk_db);
        clear = 1'b1;
        @(negedge clk_db);
        clear = 1'b0;
        void'(sb_q.pop_back());
        model_res = 0;
        chk("clear_busy",   longint'(busy), 0);
        chk("clear_result", longint'(result), 0);
        chk("clear_errs",   longint'({err_div0, err_ovf}), 0);
        n = done_cnt;
        repeat (110) @(negedge clk_db);
        chk("clear_no_done", longint'(done_cnt - n), 0);

        // asynchronous reset in the middle of a divide
        run("pre_reset_add", 2'd0, 30000, 5000, 1'b0);
        issue(2'd3, 10000, 30000, 1'b0);
        repeat (20) @(negedge clk_db);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy",   longint'(busy), 0);
        chk("rst_done",   longint'(done), 0);
        chk("rst_result", longint'(result), 0);
        chk("rst_errs",   longint'({err_div0, err_ovf}), 0);
        void'(sb_q.pop_back());
        model_res = 0;
        @(negedge clk_db);
        rst_n = 1'b1;
        run("post_reset_chain_add", 2'd0, 0, 10000, 1'b1);

        repeat (4) @(negedge clk_db);
        chk("final_scoreboard_empty", longint'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
